// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   - default operand/opcode widths and the derived result width
//   - FSM state encoding (IDLE / WAIT / DONE)
package alu_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_RES_W  = DEF_DATA_W + 1;  // ALU result carries one extra bit

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command / result handshake bundle for the ALU operation sequencer.
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op : command channel (producer -> sequencer)
//   res_valid/res_ready/res_y/res_co       : result channel  (sequencer -> consumer)
// master : the control path side (drives commands, accepts results)
// slave  : the sequencer side
interface alu_op_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W:0]   res_y;
  logic              res_co;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    input  cmd_ready, res_valid, res_y, res_co
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    output cmd_ready, res_valid, res_y, res_co
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Clocked command front-end for an external combinational ALU.
// Accepts one operation at a time, drives registered operands/opcode to the
// ALU, waits SETTLE_CYC cycles, captures Y/co and returns them on the result
// channel.
//
// Ports:
//   clk, rst_n   : clock (rising edge), async active-low reset
//   bus          : command/result handshake bundle (slave side)
//   alu_a_o/alu_b_o/alu_op_o : registered operands and opcode to the ALU
//   alu_y_i/alu_co_i         : ALU result and carry
//   busy_o       : high whenever the FSM is not idle
//   op_count_o   : number of results handed off (wraps)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no operation in flight, command channel ready
// WAIT   | operands on the ALU, settle counter running
// DONE   | result captured and offered, waiting for res_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OP_W       = DEF_OP_W,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W:0]   alu_y_i,
  input  logic              alu_co_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  op_count_o
);

  localparam int RES_W = DATA_W + 1;
  // The counter only ever holds SETTLE_CYC-1 down to 0.
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 1) begin : g_cfg_err
    $error("alu_op_sequencer: SETTLE_CYC must be at least 1");
  end

  state_e            state_q;
  logic [SW-1:0]     cnt_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [RES_W-1:0]  res_y_q;
  logic              res_co_q;
  logic              res_valid_q;
  logic [CNT_W-1:0]  op_count_q;
  logic              cmd_ready;

  // In DONE a new command can be taken in the same cycle the result leaves,
  // which is what gives one operation per SETTLE_CYC+1 cycles.
  assign cmd_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_y_q     <= '0;
      res_co_q    <= 1'b0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q  <= bus.cmd_a;
            alu_b_q  <= bus.cmd_b;
            alu_op_q <= bus.cmd_op;
            cnt_q    <= SETTLE_LD;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - SW'(1);
          end else begin
            res_y_q     <= alu_y_i;
            res_co_q    <= alu_co_i;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            op_count_q  <= op_count_q + CNT_W'(1);
            res_valid_q <= 1'b0;
            if (bus.cmd_valid) begin
              alu_a_q  <= bus.cmd_a;
              alu_b_q  <= bus.cmd_b;
              alu_op_q <= bus.cmd_op;
              cnt_q    <= SETTLE_LD;
              state_q  <= S_WAIT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_co    = res_co_q;

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_op_o   = alu_op_q;
  assign busy_o     = (state_q != S_IDLE);
  assign op_count_o = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder ALU stub and a result
// scoreboard filled at command acceptance.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 16;
  localparam int OW = 3;
  localparam int SC = 3;
  localparam int CW = 8;
  localparam int RW = DEF_RES_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(DW), .OP_W(OW)) bus ();

  logic [DW-1:0] alu_a, alu_b;
  logic [OW-1:0] alu_op;
  logic [RW-1:0] alu_y;
  logic          alu_co, busy;
  logic [CW-1:0] op_count;

  alu_op_sequencer #(.DATA_W(DW), .OP_W(OW), .SETTLE_CYC(SC), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_op_o   (alu_op),
    .alu_y_i    (alu_y),
    .alu_co_i   (alu_co),
    .busy_o     (busy),
    .op_count_o (op_count)
  );

  // ALU stub: Y = A + B, co = Y[MSB]
  assign alu_y  = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_co = alu_y[DW];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  logic [RW-1:0] sb_y[$];
  logic          sb_co[$];
  logic [DW-1:0] cq_a[$], cq_b[$];
  logic [OW-1:0] cq_op[$];
  int            acc_cyc[$], res_cyc[$];
  logic [RW-1:0] last_y;
  logic          last_co;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    cq_a.push_back(a);
    cq_b.push_back(b);
    cq_op.push_back(op);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_y.delete(); sb_co.delete();
    cq_a.delete(); cq_b.delete(); cq_op.delete();
  endtask

  // Streams the queued commands with res_ready as currently set; compares each
  // handed-off result against the scoreboard and the ALU drive after each accept.
  task automatic run_stream(input int n);
    int got, k;
    logic hand, acc;
    logic [DW-1:0] ea, eb;
    logic [OW-1:0] eop;
    logic [RW-1:0] ey;
    got = 0;
    k = 0;
    acc_cyc.delete();
    res_cyc.delete();
    while (got < n && k < 10 * n + 40) begin
      if (cq_a.size() > 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_a  = cq_a[0];
        bus.cmd_b  = cq_b[0];
        bus.cmd_op = cq_op[0];
      end else begin
        bus.cmd_valid = 1'b0;
      end
      #1;
      hand = bus.res_valid && bus.res_ready;
      acc  = bus.cmd_valid && bus.cmd_ready;
      if (hand) begin
        if (sb_y.size() > 0) begin
          chk("res_y", 32'(bus.res_y), 32'(sb_y[0]));
          chk("res_co", 32'(bus.res_co), 32'(sb_co[0]));
          void'(sb_y.pop_front());
          void'(sb_co.pop_front());
        end else begin
          chk("spurious_res_valid", 32'(bus.res_valid), 32'd0);
        end
        last_y  = bus.res_y;
        last_co = bus.res_co;
        res_cyc.push_back(cyc);
        got++;
      end
      if (acc) begin
        ea  = cq_a.pop_front();
        eb  = cq_b.pop_front();
        eop = cq_op.pop_front();
        ey  = {1'b0, ea} + {1'b0, eb};
        sb_y.push_back(ey);
        sb_co.push_back(ey[DW]);
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      k++;
      if (acc) begin
        chk("alu_a_after_accept", 32'(alu_a), 32'(ea));
        chk("alu_b_after_accept", 32'(alu_b), 32'(eb));
        chk("alu_op_after_accept", 32'(alu_op), 32'(eop));
      end
    end
    chk("stream_result_count", got, n);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_res_y", 32'(bus.res_y), 32'd0);
    chk("rst_res_co", 32'(bus.res_co), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset asserted during WAIT aborts the operation
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 16'd100;
    bus.cmd_b = 16'd200;
    bus.cmd_op = 3'd2;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("midwait_busy", 32'(busy), 32'd1);
    chk("midwait_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("midwait_alu_a", 32'(alu_a), 32'd100);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (SC + 3) begin
      @(posedge clk); #1;
      chk("no_stale_result", 32'(bus.res_valid), 32'd0);
    end
    chk("abort_op_count", 32'(op_count), 32'd0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // single operation
    bus.res_ready = 1'b1;
    push_cmd(16'd10, 16'd5, 3'b001);
    run_stream(1);
    chk("single_res_y", 32'(last_y), 32'd15);
    chk("single_res_co", 32'(last_co), 32'd0);
    chk("single_op_count", 32'(op_count), 32'd1);
    chk("single_latency", res_cyc[0] - acc_cyc[0], SC + 1);
    chk("single_idle_after", 32'(busy), 32'd0);

    // backpressure: result held, new command refused until res_ready
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 16'd20;
    bus.cmd_b = 16'd30;
    bus.cmd_op = 3'b110;
    @(posedge clk); #1;
    sb_y.push_back(17'd50);
    sb_co.push_back(1'b0);
    bus.cmd_a = 16'd7;
    bus.cmd_b = 16'd8;
    bus.cmd_op = 3'b011;
    k = 0;
    while (!bus.res_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_res_valid_seen", 32'(bus.res_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_res_valid_held", 32'(bus.res_valid), 32'd1);
      chk("bp_res_y_stable", 32'(bus.res_y), 32'd50);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_alu_a_held", 32'(alu_a), 32'd20);
    end
    push_cmd(16'd7, 16'd8, 3'b011);
    bus.res_ready = 1'b1;
    run_stream(2);
    chk("bp_last_res_y", 32'(last_y), 32'd15);
    chk("bp_op_count", 32'(op_count), 32'd3);

    // back-to-back with res_ready held high
    apply_reset();
    bus.res_ready = 1'b1;
    push_cmd(16'd1, 16'd2, 3'd0);
    push_cmd(16'd300, 16'd400, 3'd5);
    push_cmd(16'h8000, 16'h8000, 3'd7);
    run_stream(3);
    chk("b2b_spacing_1", acc_cyc[1] - acc_cyc[0], SC + 1);
    chk("b2b_spacing_2", acc_cyc[2] - acc_cyc[1], SC + 1);
    for (int i = 0; i < 3; i++) chk("b2b_latency", res_cyc[i] - acc_cyc[i], SC + 1);
    chk("b2b_last_res_y", 32'(last_y), 32'h10000);
    chk("b2b_op_count", 32'(op_count), 32'd3);

    // carry out on full-width overflow
    push_cmd(16'hFFFF, 16'h0001, 3'd0);
    run_stream(1);
    chk("carry_res_y", 32'(last_y), 32'h10000);
    chk("carry_res_co", 32'(last_co), 32'd1);
    chk("carry_op_count", 32'(op_count), 32'd4);

    // op_count wraps 255 -> 0
    apply_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 255; i++)
      push_cmd(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)));
    run_stream(255);
    chk("count_255", 32'(op_count), 32'd255);
    push_cmd(16'd3, 16'd4, 3'd1);
    run_stream(1);
    chk("count_wrap", 32'(op_count), 32'd0);
    chk("wrap_res_y", 32'(last_y), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
